// File: rtl/logic_result_checker.sv
// logic_result_checker
//   Hardware self-test checker for the bitwise And/Or logic unit. The stimulus
//   side computes the expected value for each operand pair and queues it. The
//   result side pops the queue and compares the head against the unit's output.
//   Matches and mismatches are counted with saturating counters. The first
//   mismatch after reset or clr is latched for debug.
//
// Parameters
//   WIDTH   operand/result width
//   OP_SEL  expected op: 0 = a|b, 1 = a&b (ignored when CHK_RUNTIME_OP_EN is defined)
//   DEPTH   expected-value queue depth (power of 2, >= 2)
//   CW      pass/fail counter width
//
// Ports
//   clk, rst              rising-edge clock; asynchronous active-high reset
//   stim_valid/a/b        operand pair presented this cycle
//   op_sel                per-push op select (only with CHK_RUNTIME_OP_EN)
//   res_valid/res_data    unit result presented this cycle
//   clr                   synchronous clear of all state; overrides every other input
//   pass_cnt, fail_cnt    saturating match/mismatch counters
//   pending               queue occupancy
//   overflow, underflow   sticky queue error flags
//   ff_valid/exp/got      first-fail capture
//   state                 00 IDLE, 01 RUN, 10 ERROR
//
// Configuration macro: CHK_RUNTIME_OP_EN adds the op_sel input.
module logic_result_checker #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned OP_SEL = 0,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CW     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stim_valid,
  input  logic [WIDTH-1:0]         stim_a,
  input  logic [WIDTH-1:0]         stim_b,
  input  logic                     res_valid,
  input  logic [WIDTH-1:0]         res_data,
`ifdef CHK_RUNTIME_OP_EN
  input  logic                     op_sel,
`endif
  input  logic                     clr,
  output logic [CW-1:0]            pass_cnt,
  output logic [CW-1:0]            fail_cnt,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     ff_valid,
  output logic [WIDTH-1:0]         ff_exp,
  output logic [WIDTH-1:0]         ff_got,
  output logic [1:0]               state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_ERROR = 2'b10
  } state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic [CW-1:0]    pass_q, pass_d;
  logic [CW-1:0]    fail_q, fail_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ffv_q, ffv_d;
  logic [WIDTH-1:0] ffe_q, ffe_d;
  logic [WIDTH-1:0] ffg_q, ffg_d;
  state_t           state_q, state_d;

  logic             use_and;
  logic [WIDTH-1:0] exp_val;
  logic [WIDTH-1:0] head;
  logic             full, empty;
  logic             do_push, do_pop, push_drop, unf_evt, mismatch, err_evt;
  logic             mem_we;

  // The op is resolved at push time, so storing the expected value per entry
  // carries the same information as storing the sampled op_sel.
`ifdef CHK_RUNTIME_OP_EN
  assign use_and = op_sel;
`else
  assign use_and = (OP_SEL != 0);
`endif

  always_comb begin
    exp_val   = use_and ? (stim_a & stim_b) : (stim_a | stim_b);
    head      = mem_q[rd_ptr_q];
    full      = (count_q == PW'(DEPTH));
    empty     = (count_q == '0);
    do_pop    = res_valid && !empty;
    // A pop frees the slot on the same edge, so push+pop is legal even when full.
    do_push   = stim_valid && (!full || do_pop);
    push_drop = stim_valid && full && !do_pop;
    unf_evt   = res_valid && empty;
    mismatch  = do_pop && (head != res_data);
    err_evt   = mismatch || push_drop || unf_evt;
    mem_we    = do_push && !clr;

    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + PW'(do_push) - PW'(do_pop);

    pass_d = pass_q;
    fail_d = fail_q;
    if (do_pop && !mismatch && pass_q != '1) pass_d = pass_q + CW'(1);
    if (mismatch && fail_q != '1)            fail_d = fail_q + CW'(1);

    ovf_d = ovf_q | push_drop;
    unf_d = unf_q | unf_evt;

    ffv_d = ffv_q;
    ffe_d = ffe_q;
    ffg_d = ffg_q;
    if (mismatch && !ffv_q) begin
      ffv_d = 1'b1;
      ffe_d = head;
      ffg_d = res_data;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (err_evt)         state_d = ST_ERROR;
        else if (stim_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (err_evt)              state_d = ST_ERROR;
        else if (count_d == '0)   state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pass_d   = '0;
      fail_d   = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      ffv_d    = 1'b0;
      ffe_d    = '0;
      ffg_d    = '0;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ffv_q    <= 1'b0;
      ffe_q    <= '0;
      ffg_q    <= '0;
      state_q  <= ST_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ffv_q    <= ffv_d;
      ffe_q    <= ffe_d;
      ffg_q    <= ffg_d;
      state_q  <= state_d;
    end
  end

  // Queue storage needs no reset: entries are only read when count_q says they are live.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= exp_val;
  end

  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign pending   = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign ff_valid  = ffv_q;
  assign ff_exp    = ffe_q;
  assign ff_got    = ffg_q;
  assign state     = state_q;

endmodule
